// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pio_pkg
// Purpose  : Shared widths, direction encodings, timeout data pattern and the
//            arbiter FSM state type for the PIO arbiter block.
// Revision : 1.0 - initial release
// ============================================================================
package pio_pkg;

  localparam int PIO_ADDR_W = 16;
  localparam int PIO_DATA_W = 32;

  localparam logic PIO_RD = 1'b1;
  localparam logic PIO_WR = 1'b0;

  localparam logic [PIO_DATA_W-1:0] PIO_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } pio_arb_state_e;

endpackage : pio_pkg
`default_nettype wire

// File: rtl/pio_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pio_rr_arbiter
// Purpose  : Combinational round-robin pick. The search starts one position
//            after the last granted requester and wraps around.
// Revision : 1.0 - initial release
// ============================================================================
module pio_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_gnt_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the requesters in priority order and keep the first active one.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_gnt_i) + off) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule : pio_rr_arbiter
`default_nettype wire

// File: rtl/pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pio_arbiter
// Purpose  : Shares one PIO master port among NUM_REQ requesters with
//            round-robin arbitration and a single transaction in flight.
//            Writes are posted; reads finish on rd_vld or on a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module pio_arbiter
  import pio_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [NUM_REQ*PIO_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*PIO_DATA_W-1:0] req_data_w,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            rsp_vld,
  output logic [PIO_DATA_W-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          cmd_vld,
  output logic [PIO_ADDR_W-1:0]         addr,
  output logic [PIO_DATA_W-1:0]         data_w,
  output logic                          rw,
  input  logic [PIO_DATA_W-1:0]         data_r,
  input  logic                          rd_vld
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  pio_arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]        last_gnt_q, last_gnt_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [PIO_ADDR_W-1:0]   addr_q, addr_d;
  logic [PIO_DATA_W-1:0]   data_w_q, data_w_d;
  logic                    rw_q, rw_d;
  logic [PIO_DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_REQ-1:0]      win_gnt;
  logic [IDX_W-1:0]        win_idx;
  logic [PIO_ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [PIO_DATA_W-1:0]   data_arr [NUM_REQ];

  // Split the flattened request buses into per-requester fields.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i] = req_addr[i*PIO_ADDR_W +: PIO_ADDR_W];
      assign data_arr[i] = req_data_w[i*PIO_DATA_W +: PIO_DATA_W];
    end
  endgenerate

  pio_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i      (req_vld),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (win_gnt),
    .idx_o      (win_idx)
  );

  // State and capture registers; last_gnt resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= IDX_W'(NUM_REQ - 1);
      owner_q    <= '0;
      addr_q     <= '0;
      data_w_q   <= '0;
      rw_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      data_w_q   <= data_w_d;
      rw_q       <= rw_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic and strobes; rd_vld only matters in WAIT_RD.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    data_w_d   = data_w_q;
    rw_d       = rw_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;
    req_gnt    = '0;
    rsp_vld    = '0;
    cmd_vld    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_vld) begin
          req_gnt    = win_gnt;
          last_gnt_d = win_idx;
          owner_d    = win_idx;
          addr_d     = addr_arr[win_idx];
          data_w_d   = data_arr[win_idx];
          rw_d       = req_rw[win_idx];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cmd_vld = 1'b1;
        if (rw_q == PIO_RD) begin
          cnt_d   = '0;
          state_d = WAIT_RD;
        end else begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end
      WAIT_RD: begin
        if (rd_vld) begin
          rsp_data_d = data_r;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = PIO_TIMEOUT_DATA;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rsp_vld[owner_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign addr     = addr_q;
  assign data_w   = data_w_q;
  assign rw       = rw_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule : pio_arbiter
`default_nettype wire

// File: tb/tb_pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_arbiter
// Purpose  : Directed self-checking bench for pio_arbiter (NUM_REQ=4,
//            TIMEOUT=8) with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_vld;
  logic [NUM_REQ-1:0]    req_rw;
  logic [NUM_REQ*16-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_data_w;
  logic [NUM_REQ-1:0]    req_gnt;
  logic [NUM_REQ-1:0]    rsp_vld;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic                  busy;
  logic                  cmd_vld;
  logic [15:0]           addr;
  logic [31:0]           data_w;
  logic                  rw;
  logic [31:0]           data_r;
  logic                  rd_vld;

  int n_total = 0;
  int n_pass  = 0;

  pio_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_vld    (req_vld),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_data_w (req_data_w),
    .req_gnt    (req_gnt),
    .rsp_vld    (rsp_vld),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .cmd_vld    (cmd_vld),
    .addr       (addr),
    .data_w     (data_w),
    .rw         (rw),
    .data_r     (data_r),
    .rd_vld     (rd_vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [NUM_REQ-1:0] seen_rsp;

    reset      = 1'b1;
    req_vld    = '0;
    req_rw     = '0;
    req_addr   = '0;
    req_data_w = '0;
    data_r     = '0;
    rd_vld     = 1'b0;
    tick();
    tick();

    // Reset state.
    chk("rst_busy", busy, 0);
    chk("rst_cmd_vld", cmd_vld, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data_w", data_w, 0);
    chk("rst_rw", rw, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_gnt", req_gnt, 0);
    reset = 1'b0;
    tick();

    // Single write from requester 2.
    req_addr[2*16 +: 16]   = 16'h0010;
    req_data_w[2*32 +: 32] = 32'hA5A5_0001;
    req_rw[2]              = 1'b0;
    req_vld                = 4'b0100;
    #1;
    chk("wr_gnt", req_gnt, 4'b0100);
    tick();
    req_vld = '0;
    chk("wr_cmd_vld", cmd_vld, 1);
    chk("wr_rw", rw, 0);
    chk("wr_addr", addr, 16'h0010);
    chk("wr_data", data_w, 32'hA5A5_0001);
    chk("wr_busy", busy, 1);
    tick();
    chk("wr_rsp_vld", rsp_vld, 4'b0100);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_data", rsp_data, 0);
    chk("wr_cmd_off", cmd_vld, 0);
    tick();
    chk("wr_idle", busy, 0);

    // Single read from requester 1, data three cycles after cmd_vld.
    req_addr[1*16 +: 16] = 16'h0020;
    req_rw[1]            = 1'b1;
    req_vld              = 4'b0010;
    #1;
    chk("rd_gnt", req_gnt, 4'b0010);
    tick();
    req_vld = '0;
    chk("rd_cmd_vld", cmd_vld, 1);
    chk("rd_rw", rw, 1);
    chk("rd_addr", addr, 16'h0020);
    tick();
    tick();
    tick();
    data_r = 32'h1234_5678;
    rd_vld = 1'b1;
    chk("rd_no_early_rsp", rsp_vld, 0);
    tick();
    rd_vld = 1'b0;
    data_r = '0;
    chk("rd_rsp_vld", rsp_vld, 4'b0010);
    chk("rd_rsp_data", rsp_data, 32'h1234_5678);
    chk("rd_rsp_err", rsp_err, 0);
    tick();

    // Round-robin with all requesters writing continuously from reset.
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    req_rw  = '0;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*16 +: 16] = 16'(16'h0100 + i);
    req_vld = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rr_gnt%0d", g), req_gnt, 4'b0001 << (g % NUM_REQ));
      tick();
      chk($sformatf("rr_addr%0d", g), addr, 16'h0100 + (g % NUM_REQ));
      chk($sformatf("rr_nognt_mid%0d", g), req_gnt, 0);
      tick();
      chk($sformatf("rr_rsp%0d", g), rsp_vld, 4'b0001 << (g % NUM_REQ));
      tick();
    end
    req_vld = '0;
    #1;
    chk("withdraw_gnt", req_gnt, 0);
    tick();

    // Read timeout on requester 3 (search starts at 1 after last grant 0).
    req_addr[3*16 +: 16] = 16'h0030;
    req_rw[3]            = 1'b1;
    req_vld              = 4'b1000;
    #1;
    chk("to_gnt", req_gnt, 4'b1000);
    tick();
    req_vld = '0;
    for (int c = 0; c < 8; c++) tick();
    chk("to_no_rsp_t9", rsp_vld, 0);
    chk("to_busy_t9", busy, 1);
    tick();
    chk("to_rsp_vld", rsp_vld, 4'b1000);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("to_idle_t11", busy, 0);
    tick();
    // Late rd_vld at T+12 together with a new write from requester 0.
    data_r    = 32'h5555_AAAA;
    rd_vld    = 1'b1;
    req_rw[0] = 1'b0;
    req_addr[0*16 +: 16]   = 16'h0040;
    req_data_w[0*32 +: 32] = 32'h0BAD_F00D;
    req_vld   = 4'b0001;
    #1;
    chk("late_gnt", req_gnt, 4'b0001);
    tick();
    rd_vld  = 1'b0;
    req_vld = '0;
    chk("late_cmd_vld", cmd_vld, 1);
    chk("late_rw", rw, 0);
    tick();
    chk("late_rsp_vld", rsp_vld, 4'b0001);
    chk("late_rsp_err", rsp_err, 0);
    chk("late_rsp_data", rsp_data, 0);
    tick();

    // rd_vld on the final WAIT_RD cycle beats the timeout (requester 2).
    req_rw[2] = 1'b1;
    req_vld   = 4'b0100;
    #1;
    chk("tie_gnt", req_gnt, 4'b0100);
    tick();
    req_vld = '0;
    for (int c = 0; c < 8; c++) tick();
    data_r = 32'hCAFE_F00D;
    rd_vld = 1'b1;
    chk("tie_no_rsp", rsp_vld, 0);
    tick();
    rd_vld = 1'b0;
    chk("tie_rsp_vld", rsp_vld, 4'b0100);
    chk("tie_rsp_err", rsp_err, 0);
    chk("tie_rsp_data", rsp_data, 32'hCAFE_F00D);
    tick();

    // Reset during WAIT_RD of a read from requester 1 (last grant was 2).
    req_rw[1] = 1'b1;
    req_vld   = 4'b0010;
    #1;
    chk("mr_gnt", req_gnt, 4'b0010);
    tick();
    req_vld = '0;
    tick();
    tick();
    chk("mr_in_wait", busy, 1);
    reset = 1'b1;
    tick();
    chk("mr_busy", busy, 0);
    chk("mr_cmd_vld", cmd_vld, 0);
    chk("mr_addr", addr, 0);
    chk("mr_data_w", data_w, 0);
    chk("mr_rw", rw, 0);
    chk("mr_rsp_vld", rsp_vld, 0);
    chk("mr_rsp_data", rsp_data, 0);
    chk("mr_rsp_err", rsp_err, 0);
    chk("mr_gnt_off", req_gnt, 0);
    tick();
    reset    = 1'b0;
    seen_rsp = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen_rsp = seen_rsp | rsp_vld;
    end
    chk("mr_no_late_rsp", seen_rsp, 0);
    req_rw  = '0;
    req_vld = 4'b1111;
    #1;
    chk("mr_contest_gnt", req_gnt, 4'b0001);
    tick();
    req_vld = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pio_arbiter
`default_nettype wire
